// File: rtl/la_clkdiv.sv
// la_clkdiv: glitch-free programmable clock divider with graceful stop and boundary-aligned ratio updates
module la_clkdiv #(
    parameter int    DW   = 8,
    parameter string PROP = "DEFAULT"
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [DW-1:0] div_in,
    input  logic          div_load,
    output logic          div_ack,
    output logic          clkout,
    output logic          rise,
    output logic          fall,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] TWO = {{(DW-2){1'b0}}, 2'b10};
    if (PROP == "") begin : g_prop_unset
    end
    state_t state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d, div_q, div_d, pend_q, n_next, h;
    logic pend_v_q, pend_v_d, clk_d, rise_d, fall_d, ack_d, last;
    assign h      = (div_q >> 1) + {{(DW-1){1'b0}}, div_q[0]};
    assign last   = cnt_q == div_q - ONE;
    assign n_next = pend_v_q ? pend_q : div_q;
    assign busy   = state_q != IDLE;
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        div_d    = div_q;
        pend_v_d = div_load | pend_v_q;
        clk_d    = 1'b0;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        ack_d    = 1'b0;
        if (state_q == IDLE) begin
            if (pend_v_q) begin
                div_d    = pend_q;
                ack_d    = 1'b1;
                pend_v_d = div_load;
            end else if (en && div_q >= TWO) begin
                state_d = RUN;
                clk_d   = 1'b1;
                rise_d  = 1'b1;
            end
        end else if (last) begin
            // period boundary: the only point a new ratio or a stop may take effect
            div_d    = n_next;
            ack_d    = pend_v_q;
            pend_v_d = div_load | 1'b0;
            state_d  = (en && n_next >= TWO) ? RUN : IDLE;
            clk_d    = en && n_next >= TWO;
            rise_d   = en && n_next >= TWO;
        end else begin
            cnt_d   = cnt_q + ONE;
            clk_d   = cnt_d < h;
            fall_d  = cnt_d == h;
            state_d = en ? RUN : STOPPING;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            clkout   <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
            div_ack  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            pend_q   <= div_load ? div_in : pend_q;
            pend_v_q <= pend_v_d;
            clkout   <= clk_d;
            rise     <= rise_d;
            fall     <= fall_d;
            div_ack  <= ack_d;
        end
    end
endmodule

// File: tb/tb_la_clkdiv.sv
// tb_la_clkdiv: directed checks of la_clkdiv waveform, ratio updates, stop and reset behaviour
module tb_la_clkdiv;
    logic clk = 1'b0, reset = 1'b1, en = 1'b0, div_load = 1'b0;
    logic [7:0] div_in = '0;
    logic div_ack, clkout, rise, fall, busy;
    int checks = 0, failures = 0;
    la_clkdiv #(.DW(8)) dut (
        .clk(clk), .reset(reset), .en(en), .div_in(div_in), .div_load(div_load),
        .div_ack(div_ack), .clkout(clkout), .rise(rise), .fall(fall), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check_outs(input string tag, input logic c, input logic r, input logic f, input logic b, input logic a);
        check({tag, ".clkout"}, clkout, c);
        check({tag, ".rise"}, rise, r);
        check({tag, ".fall"}, fall, f);
        check({tag, ".busy"}, busy, b);
        check({tag, ".div_ack"}, div_ack, a);
    endtask
    // expected waveform for ratio n starting at phase ph0, one sample per clk
    task automatic run_check(input string tag, input int n, input int cycles, input int ph0, input logic ack0);
        int h = (n + 1) / 2;
        for (int i = 0; i < cycles; i++) begin
            int ph = (ph0 + i) % n;
            check_outs(tag, ph < h, ph == 0, ph == h, 1'b1, ack0 && i == 0);
            tick();
        end
    endtask
    task automatic idle_check(input string tag, input int cycles, input logic ack0);
        for (int i = 0; i < cycles; i++) begin
            check_outs(tag, 1'b0, 1'b0, 1'b0, 1'b0, ack0 && i == 0);
            tick();
        end
    endtask
    task automatic start(input int n);
        reset = 1'b1; en = 1'b0;
        tick();
        reset = 1'b0; div_in = 8'(n); div_load = 1'b1;
        tick();
        div_load = 1'b0;
        check("start.pre_ack", div_ack, 1'b0);
        tick();
        check("start.ack", div_ack, 1'b1);
        check("start.idle", busy, 1'b0);
        en = 1'b1;
        tick();
    endtask
    initial begin
        tick();
        tick();
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // N=4: 1,1,0,0 repeating, then retune to 6 mid-period
        start(4);
        run_check("n4", 4, 12, 0, 1'b0);
        run_check("n4_pre", 4, 1, 0, 1'b0);
        div_in = 8'd6; div_load = 1'b1;
        run_check("n4_ld", 4, 1, 1, 1'b0);
        div_load = 1'b0;
        run_check("n4_tail", 4, 2, 2, 1'b0);
        run_check("n6", 6, 12, 0, 1'b1);
        // N=5: high 3, low 2
        start(5);
        run_check("n5", 5, 10, 0, 1'b0);
        start(2);
        run_check("n2", 2, 6, 0, 1'b0);
        start(3);
        run_check("n3", 3, 6, 0, 1'b0);
        // graceful stop from cnt==0 with N=8
        start(8);
        en = 1'b0;
        run_check("n8_stop", 8, 8, 0, 1'b0);
        idle_check("n8_idle", 3, 1'b0);
        // en reasserted while stopping: no gap
        start(4);
        en = 1'b0;
        run_check("restop", 4, 2, 0, 1'b0);
        en = 1'b1;
        run_check("rerun_a", 4, 2, 2, 1'b0);
        run_check("rerun_b", 4, 8, 0, 1'b0);
        // load coincident with boundary applies one boundary later
        start(4);
        run_check("coin_a", 4, 3, 0, 1'b0);
        div_in = 8'd6; div_load = 1'b1;
        run_check("coin_ld", 4, 1, 3, 1'b0);
        div_load = 1'b0;
        run_check("coin_b", 4, 4, 0, 1'b0);
        run_check("coin_n6", 6, 6, 0, 1'b1);
        // N=1 while running stops cleanly at the boundary
        start(4);
        run_check("stop1_a", 4, 1, 0, 1'b0);
        div_in = 8'd1; div_load = 1'b1;
        run_check("stop1_ld", 4, 1, 1, 1'b0);
        div_load = 1'b0;
        run_check("stop1_b", 4, 2, 2, 1'b0);
        idle_check("stop1_idle", 6, 1'b1);
        // largest ratio
        start(255);
        run_check("n255", 255, 510, 0, 1'b0);
        // reset while clkout high
        start(4);
        check("rst_hi.pre", clkout, 1'b1);
        reset = 1'b1;
        tick();
        check_outs("rst_hi", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // pending load discarded by reset
        reset = 1'b0; en = 1'b0; div_in = 8'd4; div_load = 1'b1;
        tick();
        div_load = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        en = 1'b1;
        idle_check("rst_pend", 4, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
